// File: rtl/i16_coef_loader.sv
// Byte-serial coefficient loader for the biquad cascade: frames fill a shadow
// bank, and a commit copies the whole shadow bank into the active bank on a sample strobe.
module i16_coef_loader #(
  parameter int NSEC = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           wr_data_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic                 sample_stb_i,
  output logic [NSEC*80-1:0]   coef_o,
  output logic                 pending_o,
  output logic                 commit_done_o,
  output logic                 err_o
);

  localparam int W = NSEC * 80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [6:0]     idx_q, idx_d;
  logic           badIdx_q, badIdx_d;
  logic [7:0]     hi_q, hi_d;
  logic           ready_q;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [W-1:0]   shadow_q;
  logic [W-1:0]   coef_q;
  logic           accept;
  logic           hdrBad;
  logic           shadowWr;
  logic           commitNow;

  assign accept = wr_valid_i && ready_q;
  assign hdrBad = (32'(wr_data_i[6:0]) >= NSEC);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    badIdx_d  = badIdx_q;
    hi_d      = hi_q;
    err_d     = err_q;
    done_d    = 1'b0;
    shadowWr  = 1'b0;
    commitNow = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (wr_data_i[7]) begin
            state_d = PEND;
          end else begin
            state_d  = DATA;
            idx_d    = wr_data_i[6:0];
            cnt_d    = 4'd0;
            badIdx_d = hdrBad;
            if (hdrBad) err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (!cnt_q[0]) hi_d = wr_data_i;
          else           shadowWr = !badIdx_q;
          if (cnt_q == 4'd9) state_d = IDLE;
        end
      end
      PEND: begin
        if (sample_stb_i) begin
          commitNow = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      badIdx_q <= 1'b0;
      hi_q     <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      badIdx_q <= badIdx_d;
      hi_q     <= hi_d;
      ready_q  <= (state_d != PEND);
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Coefficient k of section s sits at 80s + (4-k)*16 so b_0 lands in the top word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
    end else if (shadowWr) begin
      for (int s = 0; s < NSEC; s++) begin
        for (int k = 0; k < 5; k++) begin
          if (idx_q == 7'(s) && cnt_q[3:1] == 3'(k))
            shadow_q[s*80 + (4-k)*16 +: 16] <= {hi_q, wr_data_i};
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        coef_q <= '0;
    else if (commitNow) coef_q <= shadow_q;
  end

  assign coef_o        = coef_q;
  assign wr_ready_o    = ready_q;
  assign pending_o     = (state_q == PEND);
  assign commit_done_o = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_i16_coef_loader.sv
// Randomized bench for i16_coef_loader: frames are mirrored into a coefficient
// array model and every observable output is compared against it.
module tb_i16_coef_loader;

  localparam int NSEC = 4;
  localparam int W    = NSEC * 80;

  logic          clk;
  logic          rstN;
  logic [7:0]    wrData;
  logic          wrValid;
  logic          wrReady;
  logic          sampleStb;
  logic [W-1:0]  coef;
  logic          pending;
  logic          commitDone;
  logic          err;

  int nCmp = 0;
  int nBad = 0;

  logic [15:0] mShadow [NSEC][5];
  logic [15:0] mActive [NSEC][5];
  logic        mErr;

  i16_coef_loader #(.NSEC(NSEC)) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .wr_data_i     (wrData),
    .wr_valid_i    (wrValid),
    .wr_ready_o    (wrReady),
    .sample_stb_i  (sampleStb),
    .coef_o        (coef),
    .pending_o     (pending),
    .commit_done_o (commitDone),
    .err_o         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < NSEC; s++)
      for (int k = 0; k < 5; k++) begin
        mShadow[s][k] = '0;
        mActive[s][k] = '0;
      end
    mErr = 1'b0;
  endtask

  // Section s occupies [80s+79:80s], coefficients b_0..a_2 from MSB down.
  function automatic logic [W-1:0] bankVec(input bit fromShadow);
    logic [W-1:0] v = '0;
    for (int s = 0; s < NSEC; s++)
      for (int k = 0; k < 5; k++)
        v[s*80 + (4-k)*16 +: 16] = fromShadow ? mShadow[s][k] : mActive[s][k];
    return v;
  endfunction

  task automatic sendByte(input logic [7:0] b);
    int waitCnt = 0;
    wrData  = b;
    wrValid = 1'b1;
    while (!wrReady && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("byteAccepted", W'(wrReady), W'(1));
    if (wrReady) @(posedge clk);
    @(negedge clk);
    wrValid = 1'b0;
  endtask

  task automatic idleNoisy(input int n);
    repeat (n) begin
      sampleStb = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    sampleStb = 1'b0;
  endtask

  task automatic loadData(input logic [6:0] idx, input logic [79:0] vals);
    int si = int'(idx);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) idleNoisy($urandom_range(1, 3));
      sendByte(vals[79-8*i -: 8]);
    end
    if (si < NSEC)
      for (int k = 0; k < 5; k++) mShadow[si][k] = vals[79-16*k -: 16];
    checkOutput("coefStableDuringLoad", coef, bankVec(1'b0));
  endtask

  task automatic loadFrame(input logic [7:0] hdr, input logic [79:0] vals);
    sendByte(hdr);
    if (int'(hdr[6:0]) >= NSEC) mErr = 1'b1;
    checkOutput("errAfterHdr", W'(err), W'(mErr));
    loadData(hdr[6:0], vals);
  endtask

  task automatic commitFrame(input int stbDelay, input bit stbWithHdr);
    sampleStb = stbWithHdr;
    sendByte(8'h80 | 8'($urandom_range(0, 127)));
    sampleStb = 1'b0;
    checkOutput("pendingSet", W'(pending), W'(1));
    checkOutput("readyLowInPend", W'(wrReady), W'(0));
    checkOutput("coefHeldBeforeStb", coef, bankVec(1'b0));
    for (int i = 0; i < stbDelay; i++) begin
      @(negedge clk);
      checkOutput("readyLowWaiting", W'(wrReady), W'(0));
      checkOutput("coefHeldWaiting", coef, bankVec(1'b0));
    end
    sampleStb = 1'b1;
    @(negedge clk);
    sampleStb = 1'b0;
    for (int s = 0; s < NSEC; s++)
      for (int k = 0; k < 5; k++) mActive[s][k] = mShadow[s][k];
    checkOutput("coefAfterCommit", coef, bankVec(1'b0));
    checkOutput("doneHigh", W'(commitDone), W'(1));
    checkOutput("pendingCleared", W'(pending), W'(0));
    checkOutput("readyRestored", W'(wrReady), W'(1));
    @(negedge clk);
    checkOutput("doneOnePulse", W'(commitDone), W'(0));
    checkOutput("coefAfterDone", coef, bankVec(1'b0));
  endtask

  function automatic logic [79:0] randVals();
    return {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  task automatic applyStimulus();
    logic [79:0] v;

    // Directed load of section 1 with sign-boundary values.
    loadFrame(8'h01, 80'h1234_8001_7FFF_C000_0100);
    commitFrame(3, 1'b0);
    checkOutput("sec1Directed", W'(coef[159:80]), W'(80'h1234_8001_7FFF_C000_0100));
    checkOutput("othersZero", W'({coef[319:160], coef[79:0]}), W'(0));

    loadFrame(8'h00, randVals());
    loadFrame(8'h03, randVals());
    checkOutput("atomicHold", coef, bankVec(1'b0));
    commitFrame(0, 1'b0);

    loadFrame(8'h02, randVals());
    commitFrame(5, 1'b1);

    // Load header offered while a commit is still pending.
    sendByte(8'h81);
    fork
      sendByte(8'h02);
      begin
        repeat (3) begin
          checkOutput("bpHeld", W'(pending), W'(1));
          @(negedge clk);
        end
        sampleStb = 1'b1;
        @(negedge clk);
        sampleStb = 1'b0;
      end
    join
    for (int s = 0; s < NSEC; s++)
      for (int k = 0; k < 5; k++) mActive[s][k] = mShadow[s][k];
    checkOutput("bpCommitApplied", coef, bankVec(1'b0));
    checkOutput("bpPendingLow", W'(pending), W'(0));
    v = randVals();
    loadData(7'd2, v);
    commitFrame(1, 1'b0);

    loadFrame(8'h05, randVals());
    commitFrame(1, 1'b0);
    loadFrame(8'h00, randVals());
    commitFrame(2, 1'b0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 7)
        loadFrame(8'($urandom_range(0, 5)), randVals());
      else
        commitFrame($urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // Abort a frame after five data bytes with an asynchronous reset.
    sendByte(8'h01);
    for (int i = 0; i < 5; i++) sendByte(8'($urandom));
    #2 rstN = 1'b0;
    #1;
    modelReset();
    checkOutput("rstCoef", coef, W'(0));
    checkOutput("rstReady", W'(wrReady), W'(1));
    checkOutput("rstPending", W'(pending), W'(0));
    checkOutput("rstErr", W'(err), W'(0));
    checkOutput("rstDone", W'(commitDone), W'(0));
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    commitFrame(2, 1'b0);
    checkOutput("postRstCommitZero", coef, W'(0));
  endtask

  initial begin
    rstN      = 1'b0;
    wrData    = '0;
    wrValid   = 1'b0;
    sampleStb = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("initCoef", coef, W'(0));
    checkOutput("initReady", W'(wrReady), W'(1));
    checkOutput("initPending", W'(pending), W'(0));
    checkOutput("initDone", W'(commitDone), W'(0));
    checkOutput("initErr", W'(err), W'(0));
    rstN = 1'b1;
    @(negedge clk);
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
